// File: rtl/stopwatch_pkg.sv
`default_nettype none
// ============================================================================
// Module      : stopwatch_pkg
// Description : Shared constants, seven-segment patterns, converter state
//               encoding and the digit decoder for the stopwatch display.
// Revision    : 1.0 - initial release
// ============================================================================
package stopwatch_pkg;

    localparam int NUM_DIGITS = 4;
    localparam int MAX_COUNT  = 9999;
    localparam int BCD_W      = 16;

    // Active-low cathode patterns, bit 0 = segment a ... bit 6 = segment g
    localparam logic [6:0] SEG_0     = 7'h40;
    localparam logic [6:0] SEG_1     = 7'h79;
    localparam logic [6:0] SEG_2     = 7'h24;
    localparam logic [6:0] SEG_3     = 7'h30;
    localparam logic [6:0] SEG_4     = 7'h19;
    localparam logic [6:0] SEG_5     = 7'h12;
    localparam logic [6:0] SEG_6     = 7'h02;
    localparam logic [6:0] SEG_7     = 7'h78;
    localparam logic [6:0] SEG_8     = 7'h00;
    localparam logic [6:0] SEG_9     = 7'h10;
    localparam logic [6:0] SEG_BLANK = 7'h7F;

    typedef enum logic [1:0] {
        LOAD  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } conv_state_t;

    // Non-decimal nibbles cannot come out of the converter; show them dark
    function automatic logic [6:0] seg_decode(input logic [3:0] digit);
        logic [6:0] pattern;
        case (digit)
            4'd0:    pattern = SEG_0;
            4'd1:    pattern = SEG_1;
            4'd2:    pattern = SEG_2;
            4'd3:    pattern = SEG_3;
            4'd4:    pattern = SEG_4;
            4'd5:    pattern = SEG_5;
            4'd6:    pattern = SEG_6;
            4'd7:    pattern = SEG_7;
            4'd8:    pattern = SEG_8;
            4'd9:    pattern = SEG_9;
            default: pattern = SEG_BLANK;
        endcase
        return pattern;
    endfunction

endpackage
`default_nettype wire

// File: rtl/bin2bcd_seq.sv
`default_nettype none
// ============================================================================
// Module      : bin2bcd_seq
// Description : Free-running sequential double-dabble converter. One 16-cycle
//               pass per result: LOAD (1), SHIFT (14), DONE (1).
// Revision    : 1.0 - initial release
// ============================================================================
module bin2bcd_seq
    import stopwatch_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic [13:0]      bin,
    output logic [BCD_W-1:0] bcd,
    output logic             done
);

    localparam logic [13:0] c_max_count = 14'(MAX_COUNT);

    conv_state_t      r_state;
    logic [13:0]      r_bin_sr;
    logic [BCD_W-1:0] r_bcd_sr;
    logic [3:0]       r_shift_cnt;
    logic [13:0]      w_sat;
    logic [BCD_W-1:0] w_bcd_adj;

    // Clamp out-of-range counts so the display never shows garbage
    assign w_sat = (bin > c_max_count) ? c_max_count : bin;

    // Add-3 correction on every nibble that would overflow past 9 when doubled
    generate
        for (genvar i = 0; i < NUM_DIGITS; i++) begin : g_adj
            assign w_bcd_adj[4*i +: 4] = (r_bcd_sr[4*i +: 4] >= 4'd5) ?
                                         (r_bcd_sr[4*i +: 4] + 4'd3) :
                                          r_bcd_sr[4*i +: 4];
        end
    endgenerate

    assign done = (r_state == DONE);

    // Converter FSM: sample, shift 14 times, then commit the result
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= LOAD;
            r_bin_sr    <= '0;
            r_bcd_sr    <= '0;
            r_shift_cnt <= '0;
            bcd         <= '0;
        end else begin
            case (r_state)
                LOAD: begin
                    r_bin_sr    <= w_sat;
                    r_bcd_sr    <= '0;
                    r_shift_cnt <= '0;
                    r_state     <= SHIFT;
                end
                SHIFT: begin
                    {r_bcd_sr, r_bin_sr} <= {w_bcd_adj, r_bin_sr} << 1;
                    r_shift_cnt          <= r_shift_cnt + 4'd1;
                    if (r_shift_cnt == 4'd13) begin
                        r_state <= DONE;
                    end
                end
                DONE: begin
                    bcd     <= r_bcd_sr;
                    r_state <= LOAD;
                end
                default: r_state <= LOAD;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/stopwatch_display.sv
`default_nettype none
// ============================================================================
// Module      : stopwatch_display
// Description : Converts the stopwatch count to BCD and scans the four digits
//               onto a common-anode seven-segment display with optional
//               decimal point and leading-zero blanking.
// Revision    : 1.0 - initial release
// ============================================================================
module stopwatch_display
    import stopwatch_pkg::*;
#(
    parameter int REFRESH_BITS  = 17,
    parameter int DP_POS        = 2,
    parameter int BLANK_LEADING = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [13:0]           value,
    output logic [6:0]            seg,
    output logic                  dp,
    output logic [NUM_DIGITS-1:0] an,
    output logic [BCD_W-1:0]      bcd
);

    // Digits at or right of the decimal point always show, even when zero
    localparam int          c_first_blankable = (DP_POS < NUM_DIGITS) ? DP_POS : 0;
    localparam logic [2:0]  c_dp_sel          = 3'(DP_POS);

    logic [REFRESH_BITS-1:0] r_scan_cnt;
    logic [1:0]              w_sel;
    logic [3:0]              w_nibble;
    logic [BCD_W-1:0]        w_bcd;
    logic [NUM_DIGITS-1:0]   w_blank;
    logic                    w_unused_done;

    bin2bcd_seq u_conv (
        .clk   (clk),
        .reset (reset),
        .bin   (value),
        .bcd   (w_bcd),
        .done  (w_unused_done)
    );

    assign bcd      = w_bcd;
    assign w_sel    = r_scan_cnt[REFRESH_BITS-1 -: 2];
    assign w_nibble = w_bcd[{w_sel, 2'b00} +: 4];

    // A digit goes dark only when it and every digit to its left are zero
    assign w_blank[0] = 1'b0;
    generate
        for (genvar k = 1; k < NUM_DIGITS; k++) begin : g_blank
            assign w_blank[k] = (BLANK_LEADING != 0) && (k > c_first_blankable) &&
                                (w_bcd[BCD_W-1:4*k] == '0);
        end
    endgenerate

    // Scan counter plus registered pin drivers for the selected digit
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_scan_cnt <= '0;
            seg        <= SEG_BLANK;
            dp         <= 1'b1;
            an         <= '1;
        end else begin
            r_scan_cnt <= r_scan_cnt + {{(REFRESH_BITS-1){1'b0}}, 1'b1};
            an         <= ~(4'b0001 << w_sel);
            seg        <= w_blank[w_sel] ? SEG_BLANK : seg_decode(w_nibble);
            dp         <= ({1'b0, w_sel} == c_dp_sel) ? 1'b0 : 1'b1;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_stopwatch_display.sv
`default_nettype none
// ============================================================================
// Module      : tb_stopwatch_display
// Description : Directed self-checking bench; two instances differ only in
//               decimal-point position (2 and disabled).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_stopwatch_display;

    logic        clk;
    logic        reset;
    logic [13:0] value;
    logic [6:0]  seg2, seg4;
    logic        dp2, dp4;
    logic [3:0]  an2, an4;
    logic [15:0] bcd2, bcd4;

    int n_cmp;
    int n_err;

    stopwatch_display #(.REFRESH_BITS(4), .DP_POS(2), .BLANK_LEADING(1)) dut (
        .clk   (clk),
        .reset (reset),
        .value (value),
        .seg   (seg2),
        .dp    (dp2),
        .an    (an2),
        .bcd   (bcd2)
    );

    stopwatch_display #(.REFRESH_BITS(4), .DP_POS(4), .BLANK_LEADING(1)) dut4 (
        .clk   (clk),
        .reset (reset),
        .value (value),
        .seg   (seg4),
        .dp    (dp4),
        .an    (an4),
        .bcd   (bcd4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Check one displayed digit against packed expectations {d3,d2,d1,d0}
    task automatic chk_digit(input string tag, input logic [3:0] a, input logic [6:0] s,
                             input logic d, input logic [27:0] exp, input int dpp,
                             inout logic [3:0] seen);
        int idx;
        idx = -1;
        case (a)
            4'b1110: idx = 0;
            4'b1101: idx = 1;
            4'b1011: idx = 2;
            4'b0111: idx = 3;
            default: idx = -1;
        endcase
        n_cmp++;
        assert (idx >= 0) else begin
            n_err++;
            $error("FAIL %s_anode: observed %b expected exactly one low", tag, a);
        end
        if (idx >= 0) begin
            seen[idx] = 1'b1;
            chk($sformatf("%s_seg_d%0d", tag, idx), 16'(s), 16'(exp[7*idx +: 7]));
            chk($sformatf("%s_dp_d%0d", tag, idx), 16'(d), (idx == dpp) ? 16'd0 : 16'd1);
        end
    endtask

    // One full scan period (16 cycles with 4-bit refresh counter) on both DUTs
    task automatic check_scan(input string tag, input logic [27:0] exp2, input logic [27:0] exp4);
        logic [3:0] seen2, seen4;
        seen2 = 4'h0;
        seen4 = 4'h0;
        for (int c = 0; c < 16; c++) begin
            @(negedge clk);
            chk_digit({tag, "_dp2"}, an2, seg2, dp2, exp2, 2, seen2);
            chk_digit({tag, "_dp4"}, an4, seg4, dp4, exp4, 4, seen4);
        end
        chk({tag, "_scan_dp2"}, 16'(seen2), 16'h000F);
        chk({tag, "_scan_dp4"}, 16'(seen4), 16'h000F);
    endtask

    task automatic wait_bcd(input string tag, input logic [15:0] exp, input int budget);
        bit hit;
        hit = 1'b0;
        for (int k = 0; k < budget && !hit; k++) begin
            @(negedge clk);
            if (bcd2 === exp) hit = 1'b1;
        end
        chk(tag, bcd2, exp);
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        reset = 1'b1;
        value = 14'd0;

        // Reset state
        repeat (2) @(negedge clk);
        chk("rst_seg", 16'(seg2), 16'h007F);
        chk("rst_dp", 16'(dp2), 16'h0001);
        chk("rst_an", 16'(an2), 16'h000F);
        chk("rst_bcd", bcd2, 16'h0000);
        chk("rst_an4", 16'(an4), 16'h000F);

        // Value 0: digit3 blank with dp at 2; digits 3..1 blank with no dp
        reset = 1'b0;
        repeat (64) @(negedge clk);
        chk("zero_bcd", bcd2, 16'h0000);
        check_scan("zero", {7'h7F, 7'h40, 7'h40, 7'h40}, {7'h7F, 7'h7F, 7'h7F, 7'h40});

        // 1234 converts within 32 cycles
        value = 14'd1234;
        wait_bcd("bcd_1234", 16'h1234, 34);
        repeat (2) @(negedge clk);
        check_scan("v1234", {7'h79, 7'h24, 7'h30, 7'h19}, {7'h79, 7'h24, 7'h30, 7'h19});

        // Saturation
        value = 14'd12000;
        wait_bcd("bcd_sat", 16'h9999, 34);
        repeat (2) @(negedge clk);
        check_scan("v12000", {4{7'h10}}, {4{7'h10}});
        value = 14'd9999;
        repeat (34) @(negedge clk);
        chk("bcd_9999", bcd2, 16'h9999);
        chk("bcd4_9999", bcd4, 16'h9999);

        // Leading-zero blanking
        value = 14'd5;
        wait_bcd("bcd_5", 16'h0005, 34);
        repeat (2) @(negedge clk);
        check_scan("v5", {7'h7F, 7'h40, 7'h40, 7'h12}, {7'h7F, 7'h7F, 7'h7F, 7'h12});

        // Align to a LOAD cycle: first negedge after a commit
        value = 14'd77;
        wait_bcd("bcd_77", 16'h0077, 34);

        // Mid-conversion change must not disturb the conversion in flight
        value = 14'd4321;
        repeat (5) @(posedge clk);
        @(negedge clk);
        value = 14'd17;
        repeat (10) @(posedge clk);
        @(negedge clk);
        chk("mid_before_done", bcd2, 16'h0077);
        @(negedge clk);
        chk("mid_commit_4321", bcd2, 16'h4321);
        repeat (15) @(negedge clk);
        chk("mid_hold_4321", bcd2, 16'h4321);
        @(negedge clk);
        chk("mid_commit_17", bcd2, 16'h0017);

        // Asynchronous reset pulse between edges during SHIFT
        value = 14'd2468;
        repeat (4) @(negedge clk);
        #1 reset = 1'b1;
        #1;
        chk("arst_seg", 16'(seg2), 16'h007F);
        chk("arst_dp", 16'(dp2), 16'h0001);
        chk("arst_an", 16'(an2), 16'h000F);
        chk("arst_bcd", bcd2, 16'h0000);
        #1 reset = 1'b0;
        @(negedge clk);
        chk("arst_first_an", 16'(an2), 16'h000E);
        chk("arst_bcd_1", bcd2, 16'h0000);
        repeat (14) @(negedge clk);
        chk("arst_bcd_15", bcd2, 16'h0000);
        @(negedge clk);
        chk("arst_bcd_16", bcd2, 16'h2468);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/stopwatch_display.md
Name: stopwatch_display

Overview:
Downstream consumer of the stopwatch counter. Takes the 14-bit binary count (0..9999), converts it to four BCD digits with a multi-cycle sequential double-dabble engine, and time-multiplexes the digits onto a 4-digit common-anode seven-segment display. Optional decimal point and leading-zero blanking are included. All outputs go straight to board pins.

Parameters:
REFRESH_BITS, 17, width of the scan counter; the top 2 bits select the active digit (about 763 Hz per digit at 100 MHz).
DP_POS, 2, digit index (0 = rightmost) that shows the decimal point; 4 disables the dp.
BLANK_LEADING, 1, 1 enables leading-zero blanking.

Ports:
clk  input  1  system clock
reset  input  1  asynchronous, active-high reset
value  input  14  binary count from the stopwatch; values above 9999 are saturated to 9999
seg  output  7  cathodes, active-low; seg[0]=a ... seg[6]=g
dp  output  1  decimal point cathode, active-low
an  output  4  anodes, active-low; an[0] is the rightmost digit
bcd  output  16  last committed BCD digits; {d3,d2,d1,d0}, 4 bits each

Behaviour:
- Reset (asynchronous, active-high, one clock domain):
  - seg=7'h7F, dp=1, an=4'hF, bcd=16'h0000.
  - Scan counter = 0; converter state = LOAD.
- Converter FSM, free-running, 16 cycles per conversion:
  - LOAD (1 cycle): capture sat = (value>9999) ? 9999 : value. Clear the 16-bit BCD shift register. Shift count = 0.
  - SHIFT (14 cycles): each cycle, add 3 to every BCD nibble >=5, then shift {bcd_sr, bin_sr} left by 1. After the 14th shift, go to DONE.
  - DONE (1 cycle): bcd <= bcd_sr; go to LOAD.
- Conversion timing:
  - value is sampled only in LOAD; changes during SHIFT/DONE do not affect the conversion in flight.
  - Worst-case latency from a value change to the bcd update is 32 cycles.
  - bcd holds steady between DONE cycles.
- Scan:
  - The REFRESH_BITS counter increments every cycle and wraps.
  - sel = cnt[REFRESH_BITS-1 -: 2].
  - Registered outputs (1-cycle delay from sel): an = ~(4'b0001 << sel); seg = decode(bcd nibble sel); dp = (sel==DP_POS) ? 0 : 1.
- Blanking:
  - Let F = (DP_POS<4) ? DP_POS : 0.
  - Digit k (k=1..3) is blanked iff BLANK_LEADING=1, k>F, and nibbles k..3 of bcd are all zero.
  - A blanked digit keeps its anode driven but seg=7'h7F. Digit 0 is never blanked.
- Decode:
  - 0..9 use standard active-low patterns: 0=7'h40, 1=7'h79, 2=7'h24, 3=7'h30, 4=7'h19, 5=7'h12, 6=7'h02, 7=7'h78, 8=7'h00, 9=7'h10.
  - Nibbles 10..15 are unreachable; decode them as 7'h7F.
- Exactly one anode is low at any time after the first post-reset clock.
- Reset asserted mid-conversion aborts it. The FSM restarts in LOAD after deassertion and bcd stays 0 until the first DONE.

Decomposition:
- Shared package (stopwatch_pkg):
  - NUM_DIGITS=4, MAX_COUNT=9999, BCD_W=16.
  - The seven-segment constant array SEG_0..SEG_9 and SEG_BLANK=7'h7F.
  - Converter state enum {LOAD, SHIFT, DONE}.
- Sub-module bin2bcd_seq:
  - Contains the saturation, FSM and shift registers.
  - Ports: clk, reset, bin[13:0], bcd[15:0], done (1-cycle pulse at DONE).
- The top level holds the scan counter, blanking logic, decode and output registers.

Test Plan:
- Scan and reset: bench uses REFRESH_BITS=4. Assert reset, release, value=0, run 64 cycles -> bcd=16'h0000; an cycles 1110,1101,1011,0111; digit0 and digit1 seg=7'h40; digit2 seg=7'h40 with dp=0; digit3 blanked (seg=7'h7F).
- Conversion: value=1234 -> bcd=16'h1234 within 32 cycles; digit3 seg=7'h79 (not blanked); dp low only while an=1011.
- Saturation: value=9999 -> bcd=16'h9999. value=12000 -> bcd=16'h9999, all digits seg=7'h10.
- Leading blanking: value=5 with DP_POS=2 -> digit3 blank; digit2 seg=7'h40 with dp=0; digit0 seg=7'h12. Rerun with DP_POS=4 -> digits 3,2,1 blank and dp never asserted.
- Mid-conversion stability: value=4321 captured at LOAD, value changed to 17 at the 5th SHIFT cycle -> the next DONE commits 16'h4321; the following DONE commits 16'h0017.
- Asynchronous reset mid-conversion: pulse reset between clock edges during SHIFT -> outputs go to reset values immediately; after release, first DONE is 16 cycles later with the correct value.
